// File: rtl/enable_pulse_gen_pkg.sv
// Shared types and constants for the enable pulse generator.
package enable_pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } deb_state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer + debounce FSM; emits debounced level and a one-cycle press pulse.
// Latency: press is combinational in the cycle ARMING completes (2 sync + DEBOUNCE_CYCLES+1 after raw edge).
// No backpressure: free-running, the press pulse is dropped if unused.
module btn_debounce
    import enable_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic            btn_m;
    logic            btn_s;
    deb_state_t      state;
    deb_state_t      state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            level_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_m     <= 1'b0;
            btn_s     <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
        end else begin
            btn_m     <= btn_raw;
            btn_s     <= btn_m;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            btn_level <= level_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = btn_level;
        press     = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt = ARMING;
                    cnt_nxt   = '0;
                end
            end
            ARMING: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    level_nxt = 1'b1;
                    press     = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nxt = RELEASING;
                    cnt_nxt   = '0;
                end
            end
            RELEASING: begin
                // Release completes silently: only presses generate events.
                if (btn_s) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/enable_pulse_gen.sv
// Single-cycle enable strobe from either a debounced button press or a free-running prescaler.
// Latency: enable registered one cycle after the selected source event.
// No backpressure: the unselected source's event is dropped, never queued.
module enable_pulse_gen
    import enable_pulse_gen_pkg::*;
#(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    input  logic mode,
    input  logic run,
    output logic enable,
    output logic btn_level,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic          press;
    logic [PW-1:0] presc;
    logic          mode_q;
    logic          mode_vld;
    logic          mode_chg;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .press     (press)
    );

    // mode_vld masks the first cycle after reset so a mode strapped high
    // during reset is not mistaken for a switch.
    assign mode_chg = mode_vld & (mode ^ mode_q);
    // A tick coinciding with a mode switch is suppressed so the first auto
    // pulse always lands a full period after the switch.
    assign tick     = run & ~mode_chg & (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc    <= '0;
            mode_q   <= 1'b0;
            mode_vld <= 1'b0;
            enable   <= 1'b0;
        end else begin
            mode_q   <= mode;
            mode_vld <= 1'b1;
            if (!run || mode_chg || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
            enable <= ((mode == MODE_MANUAL) & press) | ((mode == MODE_AUTO) & tick);
        end
    end

endmodule

// File: tb/tb_enable_pulse_gen.sv
// Directed bench for enable_pulse_gen with TICK_DIV=4, DEBOUNCE_CYCLES=3.
module tb_enable_pulse_gen;
    import enable_pulse_gen_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic btn_raw;
    logic mode;
    logic run;
    logic enable;
    logic btn_level;
    logic tick;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc, n_pulse, first_pulse, last_pulse, first_tick;
    int bad_gap, consec;
    logic prev_en = 1'b0;
    logic level_seen, any_out;

    enable_pulse_gen #(
        .TICK_DIV        (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_raw   (btn_raw),
        .mode      (mode),
        .run       (run),
        .enable    (enable),
        .btn_level (btn_level),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        cyc         = 0;
        n_pulse     = 0;
        first_pulse = -1;
        last_pulse  = -1;
        first_tick  = -1;
        bad_gap     = 0;
        consec      = 0;
        level_seen  = 1'b0;
        any_out     = 1'b0;
    endtask

    // Advance n cycles; cycle k is observed 1ns after the k-th rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (enable) begin
                if (n_pulse == 0) first_pulse = cyc;
                else if (cyc - last_pulse != 4) bad_gap++;
                if (prev_en) consec++;
                last_pulse = cyc;
                n_pulse++;
            end
            prev_en = enable;
            if (tick && first_tick < 0) first_tick = cyc;
            if (btn_level) level_seen = 1'b1;
            if (enable || tick || btn_level) any_out = 1'b1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        btn_raw = 1'b1;
        mode    = 1'b1;
        run     = 1'b1;
        clr();

        // 1. reset holds everything low, then first tick in the 4th cycle
        step(3);
        check("rst_outputs_low", int'(any_out), 0);
        check("rst_state_idle", int'(dut.u_deb.state), int'(IDLE));
        reset_n = 1'b1;
        btn_raw = 1'b0;
        clr();
        step(6);
        check("rst_first_tick", first_tick, 3);
        check("rst_first_enable", first_pulse, 4);

        // 2. clean press in manual mode
        mode = MODE_MANUAL;
        run  = 1'b0;
        step(4);
        btn_raw = 1'b1;
        clr();
        step(10);
        check("press_latency", first_pulse, 6);
        check("press_count", n_pulse, 1);
        check("press_level", int'(btn_level), 1);
        btn_raw = 1'b0;
        clr();
        step(10);
        check("release_no_pulse", n_pulse, 0);
        check("release_level", int'(btn_level), 0);

        // 3. bounce then stable, latency from last rising edge
        btn_raw = 1'b1; step(1);
        btn_raw = 1'b0; step(1);
        btn_raw = 1'b1; step(1);
        btn_raw = 1'b0; step(1);
        btn_raw = 1'b1;
        clr();
        step(12);
        check("bounce_latency", first_pulse, 6);
        check("bounce_count", n_pulse, 1);
        btn_raw = 1'b0;
        step(10);
        clr();
        btn_raw = 1'b1; step(2);
        btn_raw = 1'b0; step(10);
        check("glitch_no_pulse", n_pulse, 0);
        check("glitch_level", int'(level_seen), 0);

        // 4. auto mode cadence and run gating
        mode = MODE_AUTO;
        run  = 1'b1;
        clr();
        step(17);
        check("auto_count", n_pulse, 4);
        check("auto_first", first_pulse, 5);
        check("auto_gap", bad_gap, 0);
        check("auto_no_back2back", consec, 0);
        run = 1'b0;
        clr();
        step(3);
        check("run_off_no_pulse", n_pulse, 0);
        run = 1'b1;
        clr();
        step(8);
        check("run_resume_first", first_pulse, 4);

        // 5. press in auto mode discarded; switch 0->1 restarts prescaler
        run     = 1'b0;
        btn_raw = 1'b1;
        clr();
        step(10);
        check("auto_press_dropped", n_pulse, 0);
        check("auto_press_level", int'(level_seen), 1);
        btn_raw = 1'b0;
        step(10);
        mode = MODE_MANUAL;
        run  = 1'b1;
        clr();
        step(7);
        check("manual_ticks_dropped", n_pulse, 0);
        check("manual_tick_seen", int'(first_tick >= 0), 1);
        mode = MODE_AUTO;
        clr();
        step(9);
        check("switch_first", first_pulse, 5);
        check("switch_count", n_pulse, 2);

        // 6. reset in the middle of ARMING
        mode    = MODE_MANUAL;
        run     = 1'b0;
        btn_raw = 1'b1;
        clr();
        step(4);
        check("mid_state_arming", int'(dut.u_deb.state), int'(ARMING));
        check("mid_cnt", int'(dut.u_deb.cnt), 1);
        reset_n = 1'b0;
        btn_raw = 1'b0;
        clr();
        step(2);
        check("mid_rst_idle", int'(dut.u_deb.state), int'(IDLE));
        check("mid_rst_outputs", int'(any_out), 0);
        reset_n = 1'b1;
        step(10);
        check("mid_rst_no_pulse", n_pulse, 0);
        check("mid_rst_level", int'(level_seen), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
